// File: rtl/mem_access_unit_if.sv
// Pipeline-side bundle of the MEM-stage load/store unit: request fields in,
// load result and stall/error status out.
interface mem_access_unit_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        stall;
    logic        addr_err;

    modport master (output req, op, addr, wdata, input rd_data, stall, addr_err);
    modport slave  (input req, op, addr, wdata, output rd_data, stall, addr_err);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: maps byte addresses onto a word memory, extends loads,
// and runs SB/SH as a stalled read-modify-write (merge registered, write next cycle).
module mem_access_unit #(
    parameter logic [31:0] ADDR_BASE      = 32'h10010000,
    parameter int          MEM_WORDS_LOG2 = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mem_access_unit_if.slave          pipe,
    output logic [7:0]                err_count,
    output logic [MEM_WORDS_LOG2-1:0] dm_addr,
    output logic [31:0]               dm_wdata,
    output logic                      dm_we,
    input  logic [31:0]               dm_rdata
);
    localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                           OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state, state_nxt;
    logic [31:0] off;
    logic [1:0]  lane;
    logic        out_of_window, misaligned, addr_err, ok_req, start_rmw;
    logic [31:0] merged, merge_reg;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign off           = pipe.addr - ADDR_BASE;
    assign lane          = off[1:0];
    assign dm_addr       = off[MEM_WORDS_LOG2+1:2];
    assign out_of_window = |off[31:MEM_WORDS_LOG2+2];

    always_comb begin
        misaligned = 1'b0;
        case (pipe.op)
            OP_LW, OP_SW:          misaligned = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH:  misaligned = lane[0];
            default:               misaligned = 1'b0;
        endcase
    end

    assign addr_err      = pipe.req & (out_of_window | misaligned);
    assign pipe.addr_err = addr_err;
    assign ok_req        = pipe.req & ~addr_err;
    assign start_rmw     = (state == IDLE) & ok_req & ((pipe.op == OP_SB) | (pipe.op == OP_SH));

    assign byte_sel = dm_rdata[{lane, 3'b000} +: 8];
    assign half_sel = dm_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        merged = dm_rdata;
        if (pipe.op == OP_SB)
            merged[{lane, 3'b000} +: 8] = pipe.wdata[7:0];
        else
            merged[{lane[1], 4'b0000} +: 16] = pipe.wdata[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            merge_reg <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (start_rmw)
                merge_reg <= merged;
            if (addr_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // The held store is still on the inputs during WRITE, so WRITE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_rmw) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pipe.stall   = 1'b0;
        dm_we        = 1'b0;
        dm_wdata     = pipe.wdata;
        pipe.rd_data = '0;
        if (state == WRITE) begin
            dm_we    = 1'b1;
            dm_wdata = merge_reg;
        end else begin
            pipe.stall = start_rmw;
            dm_we      = ok_req & (pipe.op == OP_SW);
            if (ok_req) begin
                case (pipe.op)
                    OP_LW:   pipe.rd_data = dm_rdata;
                    OP_LB:   pipe.rd_data = {{24{byte_sel[7]}}, byte_sel};
                    OP_LBU:  pipe.rd_data = {24'd0, byte_sel};
                    OP_LH:   pipe.rd_data = {{16{half_sel[15]}}, half_sel};
                    OP_LHU:  pipe.rd_data = {16'd0, half_sel};
                    default: pipe.rd_data = '0;
                endcase
            end
        end
        // Reset must cut a pending write before the falling edge commits it.
        if (!rst_n) begin
            pipe.stall = 1'b0;
            dm_we      = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model on the falling edge, directed cases
// plus randomized ops checked against an arithmetic reference of the load/store rules.
module tb_mem_access_unit;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int WORDS = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  err_count;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_we;

    logic [31:0] mem       [WORDS];
    logic [31:0] model_mem [WORDS];
    int          model_err = 0;
    int          n_cmp = 0, n_err = 0;
    int          stall_cycles = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.ADDR_BASE(BASE), .MEM_WORDS_LOG2(11)) dut (
        .clk(clk), .rst_n(rst_n), .pipe(bus.slave), .err_count(err_count),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr];
    always @(negedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;
    always @(posedge clk) if (bus.stall) stall_cycles = stall_cycles + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd5) return 4;
        if (o == 3'd1 || o == 3'd2 || o == 3'd6) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] w, input int l);
        logic [31:0] v;
        case (o)
            3'd0: return w;
            3'd1, 3'd2: begin
                v = (w >> (8 * l)) & 32'hFF;
                if (o == 3'd1 && v >= 32'd128) v = v + 32'hFFFFFF00;
                return v;
            end
            default: begin
                v = (w >> (16 * (l / 2))) & 32'hFFFF;
                if (o == 3'd3 && v >= 32'd32768) v = v + 32'hFFFF0000;
                return v;
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] o, input logic [31:0] old,
                                              input int l, input logic [31:0] wd);
        logic [31:0] mask;
        if (o == 3'd5) return wd;
        mask = ((o == 3'd6) ? 32'hFF : 32'hFFFF) << (8 * l);
        return (old & ~mask) | ((wd << (8 * l)) & mask);
    endfunction

    task automatic idle();
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] off, exp_rd, newval;
        int          word, l;
        logic        err, rmw;
        off    = a - BASE;
        word   = int'(off[12:2]);
        l      = int'(off[1:0]);
        err    = (off >= 32'd8192) || ((off % op_size(o)) != 0);
        rmw    = !err && (o == 3'd6 || o == 3'd7);
        exp_rd = (!err && o <= 3'd4) ? ref_load(o, model_mem[word], l) : 32'd0;
        newval = ref_store(o, model_mem[word], l, wd);

        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = wd;
        #1;
        check("err_count", {24'd0, err_count}, model_err);
        check("addr_err", {31'd0, bus.addr_err}, {31'd0, err});
        check("rd_data", bus.rd_data, exp_rd);
        check("stall", {31'd0, bus.stall}, {31'd0, rmw});
        check("dm_we", {31'd0, dm_we}, {31'd0, (!err && o == 3'd5)});
        if (!err) check("dm_addr", {21'd0, dm_addr}, word);
        if (!err && o == 3'd5) check("sw_wdata", dm_wdata, wd);
        if (rmw) begin
            @(posedge clk); #2;
            check("wr_stall", {31'd0, bus.stall}, 32'd0);
            check("wr_we", {31'd0, dm_we}, 32'd1);
            check("wr_wdata", dm_wdata, newval);
            check("wr_addr", {21'd0, dm_addr}, word);
        end
        if (err) begin
            if (model_err < 255) model_err++;
        end else if (o >= 3'd5) begin
            model_mem[word] = newval;
        end
    endtask

    initial begin
        logic [31:0] a, v;
        logic [2:0]  o;
        int          s0, diffs;

        bus.req = 1'b0; bus.op = 3'd0; bus.addr = BASE; bus.wdata = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom;
            mem[i] <= v;
            model_mem[i] = v;
        end
        mem[2] <= 32'h8899AABB;
        model_mem[2] = 32'h8899AABB;
        #1;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_we", {31'd0, dm_we}, 32'd0);
        check("rst_errcnt", {24'd0, err_count}, 32'd0);
        check("rst_rd", bus.rd_data, 32'd0);
        #12 rst_n = 1'b1;

        // Word round trip and sub-word loads
        do_op(3'd5, 32'h10010004, 32'hDEADBEEF);
        do_op(3'd0, 32'h10010004, 32'd0);
        do_op(3'd1, 32'h10010009, 32'd0);
        check("lb_lane1", bus.rd_data, 32'hFFFFFFAA);
        do_op(3'd2, 32'h10010009, 32'd0);
        check("lbu_lane1", bus.rd_data, 32'h000000AA);
        do_op(3'd3, 32'h1001000A, 32'd0);
        check("lh_hi", bus.rd_data, 32'hFFFF8899);
        do_op(3'd4, 32'h1001000A, 32'd0);
        check("lhu_hi", bus.rd_data, 32'h00008899);

        // SB read-modify-write followed directly by a load of the same word
        do_op(3'd5, 32'h10010004, 32'h11223344);
        idle();
        s0 = stall_cycles;
        do_op(3'd6, 32'h10010006, 32'h000000EE);
        do_op(3'd0, 32'h10010004, 32'd0);
        check("sb_merged", bus.rd_data, 32'h11EE3344);
        idle();
        check("stall_total", stall_cycles - s0, 32'd1);

        // Error cases
        do_op(3'd0, 32'h10010002, 32'd0);
        do_op(3'd7, 32'h10010001, 32'h0000BEEF);
        do_op(3'd5, 32'h10012000, 32'hCAFEF00D);
        idle();
        check("err_after3", {24'd0, err_count}, 32'd3);

        // Randomized mix around and outside the window
        for (int i = 0; i < 250; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE + 32'd8192 + $urandom_range(0, 63);
                default: a = BASE + $urandom_range(0, 8191);
            endcase
            if ($urandom_range(0, 1) == 1) a = a & ~(op_size(o) - 1);
            do_op(o, a, $urandom);
        end
        idle();

        // Saturation
        for (int i = 0; i < 300; i++) do_op(3'd0, BASE + 32'd1, 32'd0);
        idle();
        check("err_sat", {24'd0, err_count}, 32'hFF);

        // Reset asserted while the SH write is pending
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = 3'd7; bus.addr = BASE + 32'h12; bus.wdata = 32'h0000A5A5;
        #1 check("rmw_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        check("rmw_write_we", {31'd0, dm_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'd0, dm_we}, 32'd0);
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        check("abort_errcnt", {24'd0, err_count}, 32'd0);
        @(negedge clk); #1;
        check("abort_mem", mem[4], model_mem[4]);
        bus.req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_err = 0;
        do_op(3'd0, BASE + 32'h10, 32'd0);
        idle();

        diffs = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== model_mem[i]) diffs++;
        check("mem_image", diffs, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the word-wide data memory (11-bit word address, 32-bit data, combinational read, write on falling clk edge).
- Translates pipeline byte addresses and MIPS load/store opcodes (LW/LB/LBU/LH/LHU/SW/SB/SH) into word accesses.
- Extracts and extends load data, and performs sub-word stores as a two-cycle read-modify-write with a pipeline stall.
- Flags misaligned or out-of-range accesses and counts them.

Parameters:
- ADDR_BASE, 32'h10010000, byte address mapped to memory word 0.
- MEM_WORDS_LOG2, 11, log2 of memory depth in words; window is 4*2^MEM_WORDS_LOG2 bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  valid memory op this cycle; held stable by pipeline while stall=1.
- op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte/half used for SB/SH.
- rd_data  out  32  extended load result, combinational.
- stall  out  1  freeze upstream pipeline this cycle.
- addr_err  out  1  current request is misaligned or out of window.
- err_count  out  8  saturating count of errored requests.
- dm_addr  out  MEM_WORDS_LOG2  word address to memory.
- dm_wdata  out  32  word to write.
- dm_we  out  1  memory write enable.
- dm_rdata  in  32  memory read word (combinational from dm_addr).

Behaviour:
- Address mapping:
  - off = addr - ADDR_BASE (32-bit, wrap allowed).
  - dm_addr = off[MEM_WORDS_LOG2+1:2].
  - lane = off[1:0].
- Error conditions:
  - out of window: off >= 4*2^MEM_WORDS_LOG2.
  - misaligned: LW/SW with lane!=0; LH/LHU/SH with lane[0]=1.
  - addr_err = req & (out of window | misaligned); combinational.
  - Errored request: dm_we=0, rd_data=0, stall=0, no state change except err_count.
- Loads (single cycle, no state change): byte lanes are little-endian (lane 0 = bits 7:0).
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend half off[1]. LHU: zero-extend it.
  - LW: whole word.
  - rd_data=0 when req=0, on any store, or on error.
- SW: single cycle, dm_we=1, dm_wdata=wdata, stall=0.
- SB/SH state machine. The merge happens in two cycles so there is no dm_rdata->merge->dm_wdata path within a half clock.
  - States: IDLE, WRITE.
  - IDLE with valid SB/SH and no error:
    - stall=1, dm_we=0.
    - At the rising edge, merge_reg <= dm_rdata with the target lane(s) replaced by wdata[7:0]/wdata[15:0]; go to WRITE.
  - WRITE:
    - stall=0, dm_we=1, dm_wdata=merge_reg, dm_addr from the held addr.
    - Next rising edge -> IDLE.
  - In WRITE, req/op/addr are still the held request. The pipeline advances at the end of WRITE; the FSM never re-detects the same store.
- In IDLE for any other case, dm_wdata=wdata (don't-care when dm_we=0).
- err_count:
  - Increments by 1 at each rising edge where addr_err=1.
  - Saturates at 8'hFF.
  - Never counts twice per request, since errored requests never stall.
- Reset values (asynchronous, rst_n=0):
  - state=IDLE, merge_reg=0, err_count=0.
  - Outputs while in reset: stall=0, dm_we=0.
  - Reset asserted in WRITE aborts the write: no memory update, since dm_we drops immediately.
- req=0: dm_we=0, stall=0, rd_data=0, FSM stays IDLE.

Test Plan:
- Word round trip: SW addr=0x10010004 wdata=0xDEADBEEF -> dm_addr=1, dm_we=1 for one cycle, stall=0; then LW same addr -> rd_data=0xDEADBEEF.
- Loads from word 0x8899AABB at 0x10010008:
  - LB lane 1 (0x10010009) -> 0xFFFFFFAA.
  - LBU lane 1 -> 0x000000AA.
  - LH 0x1001000A -> 0xFFFF8899.
  - LHU 0x1001000A -> 0x00008899.
- SB RMW: word 1 = 0x11223344; SB 0x10010006 wdata=0x000000EE:
  - cycle 1: stall=1, dm_we=0.
  - cycle 2: dm_we=1, dm_wdata=0x11EE3344.
  - then IDLE; LW returns 0x11EE3344.
- Errors:
  - LW 0x10010002 -> addr_err=1, rd_data=0, err_count 0->1.
  - SH 0x10010001 -> addr_err=1, no write.
  - SW 0x10012000 (off=8192) -> addr_err=1, dm_we=0.
  - 300 consecutive errors -> err_count=0xFF.
- Reset mid-RMW: SH accepted, rst_n=0 during WRITE -> dm_we=0 immediately, memory word unchanged, state IDLE, err_count=0 after release.
- Back-to-back ops: SB then LW to same word on next pipeline slot -> LW sees merged value; stall asserted exactly one cycle total.
